ctrl_fsm: RTL and testbench

Parametrised successor to the single-cycle fetch/execute controller. It is a multi-cycle fetch/decode/execute state machine with a ready/request memory handshake, a configurable register file and datapath width, and a conditional branch. It sits between the unified memory module and the address ALU. It owns the PC (program counter), the accumulator and the general registers, and sends every PC update through the address ALU.

---
 rtl/ctrl_pkg.sv | 14 +
 rtl/ctrl_fsm_if.sv | 11 +
 rtl/ctrl_regfile.sv | 18 +
 rtl/ctrl_fsm.sv | 77 +++++++
 tb/tb_ctrl_fsm.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, FSM state encoding and ALU op shared by the controller
package ctrl_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_B    = 4'h4;
  localparam logic [3:0] OP_BZ   = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_MOVA = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_SET  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_NEXT, S_HALT} state_t;
endpackage

// File: rtl/ctrl_fsm_if.sv
// ctrl_fsm_if: request/ready memory handshake between controller and unified memory
interface ctrl_fsm_if #(parameter int DATA_W = 8, parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_wdata;
  logic mem_req;
  logic mem_we;
  logic mem_ready;
  modport master (output mem_addr, mem_wdata, mem_req, mem_we, input mem_rdata, mem_ready);
  modport slave (input mem_addr, mem_wdata, mem_req, mem_we, output mem_rdata, mem_ready);
endinterface

// File: rtl/ctrl_regfile.sv
// ctrl_regfile: NUM_REGS x DATA_W registers, sync write, combinational read, sync clear
module ctrl_regfile #(
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_we,
  input  logic [$clog2(NUM_REGS)-1:0] i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  always_ff @(posedge clk)
    if (rst) r_regs <= '{default: '0};
    else if (i_we) r_regs[i_idx] <= i_wdata;
  assign o_rdata = r_regs[i_idx];
endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle fetch/exec/mem/next controller; every PC update goes through the address ALU
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NUM_REGS = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clock,
  input  logic reset,
  ctrl_fsm_if.master mem,
  output logic [ADDR_W-1:0] inst_address,
  output logic [ADDR_W-1:0] inst_offset,
  input  logic [ADDR_W-1:0] new_inst_address,
  output logic [2:0] inst_op_select,
  output logic halted,
  output logic retire
);
  localparam int OPND_W = DATA_W - 4;
  localparam int IDX_W = $clog2(NUM_REGS);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_acc, r_instr, w_reg;
  logic [3:0] w_op;
  logic [OPND_W-1:0] w_opnd;
  logic r_taken, w_xfer;
  assign w_op = r_instr[DATA_W-1 -: 4];
  assign w_opnd = r_instr[OPND_W-1:0];
  assign w_xfer = mem.mem_req && mem.mem_ready;
  ctrl_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk(clock),
    .rst(reset),
    .i_we(r_state == S_EXEC && w_op == OP_MOV),
    .i_idx(w_opnd[IDX_W-1:0]),
    .i_wdata(r_acc),
    .o_rdata(w_reg)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: w_next = w_xfer ? S_EXEC : S_FETCH;
      S_EXEC:  w_next = (w_op == OP_LD || w_op == OP_ST) ? S_MEM : w_op == OP_HALT ? S_HALT : S_NEXT;
      S_MEM:   w_next = w_xfer ? S_NEXT : S_MEM;
      S_NEXT:  w_next = S_FETCH;
      default: w_next = r_state;
    endcase
  end
  // reset gates the request so no transfer is ever offered while reset is held
  assign mem.mem_req = !reset && (r_state == S_FETCH || r_state == S_MEM);
  assign mem.mem_we = r_state == S_MEM && w_op == OP_ST;
  assign mem.mem_addr = r_state == S_MEM ? ADDR_W'(w_reg) : r_pc;
  assign mem.mem_wdata = r_acc;
  assign inst_address = r_pc;
  assign inst_offset = (r_state == S_NEXT && r_taken) ? ADDR_W'($signed(w_opnd)) : ADDR_W'(1);
  assign inst_op_select = ALU_OP_ADD;
  assign halted = r_state == S_HALT;
  assign retire = r_state == S_NEXT;
  always_ff @(posedge clock)
    if (reset) begin
      r_state <= S_FETCH;
      r_pc <= RESET_PC;
      r_acc <= '0;
      r_instr <= {OP_NOP, {OPND_W{1'b0}}};
      r_taken <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && w_xfer) r_instr <= mem.mem_rdata;
      if (r_state == S_EXEC) begin
        r_taken <= w_op == OP_B || (w_op == OP_BZ && r_acc == '0);
        if (w_op == OP_MOVA) r_acc <= w_reg;
        if (w_op == OP_SET) r_acc <= {r_acc[DATA_W-1 -: 4], w_opnd};
      end
      if (r_state == S_MEM && w_xfer && w_op == OP_LD) r_acc <= mem.mem_rdata;
      if (r_state == S_NEXT) r_pc <= new_inst_address;
    end
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: table vectors, directed corner sequences and random programs against an ISA-level model
module tb_ctrl_fsm;
  import ctrl_pkg::*;
  logic clock = 0, reset = 1;
  logic [7:0] inst_address, inst_offset;
  logic [2:0] inst_op_select;
  logic halted, retire;
  ctrl_fsm_if #(.DATA_W(8), .ADDR_W(8)) bus ();
  ctrl_fsm #(.DATA_W(8), .ADDR_W(8), .NUM_REGS(8), .RESET_PC(8'h00)) dut (
    .clock(clock), .reset(reset), .mem(bus),
    .inst_address(inst_address), .inst_offset(inst_offset),
    .new_inst_address(8'(inst_address + inst_offset)),
    .inst_op_select(inst_op_select), .halted(halted), .retire(retire)
  );
  always #5 clock = ~clock;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {logic [7:0] addr; logic we; logic [7:0] wdata;} xfer_t;
  typedef struct {logic [7:0] i0, i1, off, npc;} vec_t;
  xfer_t xq[$];
  vec_t tbl[9];
  logic [7:0] mem [256];
  logic [7:0] mm [256];
  logic [7:0] mr [8];
  logic [7:0] mpc, macc, ins, e_off, e_addr, e_wd, e_pc, ia, off;
  logic [3:0] op, opd;
  logic taken, ismem, dr, dh, stop;
  int waits = 0, wcnt = 0, rand_waits = 0, n_pass = 0, n_chk = 0, cn, st;
  logic c_req, c_we, c_acc, c_retire, c_stall, p_req = 0, p_acc = 0, p_we = 0;
  logic [7:0] c_addr, c_wdata, c_off, c_ia, p_addr = 0, p_wdata = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // one clock: memory responds, pre-edge outputs are sampled, accepted writes land after the edge
  task automatic cyc();
    xfer_t x;
    #1;
    bus.mem_rdata = mem[bus.mem_addr];
    bus.mem_ready = bus.mem_req ? (wcnt >= waits) : 1'($urandom);
    #1;
    c_req = bus.mem_req; c_we = bus.mem_we; c_addr = bus.mem_addr; c_wdata = bus.mem_wdata;
    c_acc = c_req && bus.mem_ready; c_stall = c_req && !bus.mem_ready;
    c_retire = retire; c_off = inst_offset; c_ia = inst_address;
    if (c_req && p_req && !p_acc) begin
      check("stable_addr", c_addr, p_addr);
      check("stable_we", c_we, p_we);
      check("stable_wdata", c_wdata, p_wdata);
    end
    p_req = c_req; p_acc = c_acc; p_addr = c_addr; p_we = c_we; p_wdata = c_wdata;
    if (c_acc) begin
      x = '{c_addr, c_we, c_wdata};
      xq.push_back(x);
    end
    @(posedge clock);
    if (reset) wcnt = 0;
    else if (c_acc) begin
      if (c_we) mem[c_addr] = c_wdata;
      wcnt = 0;
      if (rand_waits != 0) waits = $urandom_range(0, 2);
    end else if (c_req) wcnt++;
    @(negedge clock);
  endtask

  task automatic run_inst(output int cyc_n, output int stl, output logic [7:0] r_ia, output logic [7:0] r_off,
                          output logic d_ret, output logic d_halt);
    cyc_n = 0; stl = 0; r_ia = 0; r_off = 0; d_ret = 0; d_halt = 0;
    while (!d_ret && !d_halt && cyc_n < 40) begin
      cyc();
      cyc_n++;
      stl += int'(c_stall);
      if (c_retire) begin d_ret = 1; r_ia = c_ia; r_off = c_off; end
      d_halt = halted;
    end
    if (!d_ret && !d_halt) check("inst_timeout", 1, 0);
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    xq.delete();
  endtask

  initial begin
    bus.mem_rdata = 0;
    bus.mem_ready = 0;
    tbl[0] = '{8'hC0, 8'h52, 8'h02, 8'h03};
    tbl[1] = '{8'hC1, 8'h52, 8'h01, 8'h02};
    tbl[2] = '{8'h00, 8'h4E, 8'hFE, 8'hFF};
    tbl[3] = '{8'h00, 8'h47, 8'h07, 8'h08};
    tbl[4] = '{8'h00, 8'h48, 8'hF8, 8'hF9};
    tbl[5] = '{8'hC5, 8'h00, 8'h01, 8'h02};
    tbl[6] = '{8'h00, 8'h40, 8'h00, 8'h01};
    tbl[7] = '{8'hC0, 8'h5F, 8'hFF, 8'h00};
    tbl[8] = '{8'hCF, 8'h5F, 8'h01, 8'h02};
    @(negedge clock);

    // straight line with reset-state checks
    clr_mem();
    mem[0] = 8'hC5; mem[1] = 8'h00; mem[2] = 8'hB0;
    reset = 1;
    cyc();
    cyc();
    check("rst_req", bus.mem_req, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_halted", halted, 0);
    check("rst_retire", retire, 0);
    check("rst_addr", bus.mem_addr, 8'h00);
    check("rst_wdata", bus.mem_wdata, 8'h00);
    check("rst_off", inst_offset, 8'h01);
    check("rst_opsel", inst_op_select, 3'b000);
    check("rst_ia", inst_address, 8'h00);
    reset = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 1) check("first_req", c_req, 1);
      check("line_retire", c_retire, 32'(k == 3 || k == 6));
    end
    check("line_pc", inst_address, 8'h02);
    xq.delete();
    run_inst(cn, st, ia, off, dr, dh);
    check("line_st_cycles", cn, 4);
    check("line_acc", mem[0], 8'h05);

    // table: setup instruction at 0, control-flow instruction at 1
    foreach (tbl[i]) begin
      clr_mem();
      mem[0] = tbl[i].i0; mem[1] = tbl[i].i1;
      do_reset();
      run_inst(cn, st, ia, off, dr, dh);
      run_inst(cn, st, ia, off, dr, dh);
      check("tbl_off", off, tbl[i].off);
      check("tbl_pc", inst_address, tbl[i].npc);
    end

    // backward branch at 0x03
    clr_mem();
    mem[3] = 8'h4E;
    do_reset();
    for (int k = 0; k < 4; k++) run_inst(cn, st, ia, off, dr, dh);
    check("bb_ia", ia, 8'h03);
    check("bb_off", off, 8'hFE);
    check("bb_pc", inst_address, 8'h01);

    // BZ at 0x10 with acc zero / nonzero
    for (int a = 0; a < 2; a++) begin
      clr_mem();
      mem[0] = 8'h47; mem[7] = 8'h47; mem[8'h0E] = (a != 0) ? 8'hC1 : 8'hC0; mem[8'h10] = 8'h52;
      do_reset();
      for (int k = 0; k < 5; k++) run_inst(cn, st, ia, off, dr, dh);
      check("bz_ia", ia, 8'h10);
      check("bz_pc", inst_address, (a != 0) ? 8'h11 : 8'h12);
    end

    // LD/ST with two wait states, then HALT
    clr_mem();
    mem[0] = 8'hA0; mem[1] = 8'h81; mem[2] = 8'hA1; mem[3] = 8'h82; mem[4] = 8'hC1; mem[5] = 8'h83;
    mem[6] = 8'hA3; mem[7] = 8'hB2; mem[8] = 8'hC0; mem[9] = 8'hA2; mem[10] = 8'hB0; mem[11] = 8'hF0;
    mem[8'hA0] = 8'h40; mem[8'h41] = 8'h3C;
    do_reset();
    waits = 2;
    dh = 0;
    for (int k = 0; k < 14 && !dh; k++) begin
      xq.delete();
      run_inst(cn, st, ia, off, dr, dh);
      if (k == 7) begin
        check("st_cycles", cn, 8);
        check("st_nxfer", xq.size(), 2);
        if (xq.size() == 2) begin
          check("st_addr", xq[1].addr, 8'h40);
          check("st_we", xq[1].we, 1);
          check("st_wdata", xq[1].wdata, 8'h3C);
        end
      end
    end
    check("ldst_mem40", mem[8'h40], 8'h3C);
    check("ldst_acc", mem[0], 8'h3C);
    check("halt_flag", halted, 1);
    for (int k = 0; k < 20; k++) begin
      cyc();
      check("halt_noreq", c_req, 0);
    end
    check("halt_pc", inst_address, 8'h0B);
    check("halt_stays", halted, 1);
    waits = 0;

    // reset while a fetch is stalled
    clr_mem();
    mem[0] = 8'h47;
    do_reset();
    run_inst(cn, st, ia, off, dr, dh);
    waits = 5;
    cyc();
    cyc();
    check("mid_req_before", bus.mem_req, 1);
    check("mid_addr_before", bus.mem_addr, 8'h07);
    reset = 1;
    cyc();
    check("mid_req_after", bus.mem_req, 0);
    check("mid_pc", inst_address, 8'h00);
    cyc();
    reset = 0;
    waits = 0;
    cyc();
    check("mid_refetch_req", c_req, 1);
    check("mid_refetch_addr", c_addr, 8'h00);

    // random programs against the ISA model
    do_reset();
    for (int i = 0; i < 256; i++) begin
      ins = 8'($urandom);
      if (ins[7:4] == 4'hF) ins[7:4] = 4'h0;
      mem[i] = ins; mm[i] = ins;
    end
    do_reset();
    mpc = 0; macc = 0; mr = '{default: 8'h00};
    rand_waits = 1;
    stop = 0;
    for (int n = 0; n < 400 && !stop; n++) begin
      ins = mm[mpc]; op = ins[7:4]; opd = ins[3:0];
      taken = op == OP_B || (op == OP_BZ && macc == 0);
      e_off = taken ? {{4{opd[3]}}, opd} : 8'h01;
      ismem = op == OP_LD || op == OP_ST;
      e_addr = mr[opd[2:0]]; e_wd = macc; e_pc = mpc;
      if (op == OP_MOV) mr[opd[2:0]] = macc;
      else if (op == OP_MOVA) macc = mr[opd[2:0]];
      else if (op == OP_LD) macc = mm[e_addr];
      else if (op == OP_ST) mm[e_addr] = macc;
      else if (op == OP_SET) macc = {macc[7:4], opd};
      mpc = mpc + e_off;
      xq.delete();
      run_inst(cn, st, ia, off, dr, dh);
      if (op == OP_HALT) begin
        check("rnd_halt", dh, 1);
        stop = 1;
      end else begin
        check("rnd_retire", dr, 1);
        check("rnd_ia", ia, e_pc);
        check("rnd_off", off, e_off);
        check("rnd_cycles", cn, 3 + int'(ismem) + st);
        check("rnd_nxfer", xq.size(), 1 + int'(ismem));
      end
      if (xq.size() > 0) begin
        check("rnd_fetch_addr", xq[0].addr, e_pc);
        check("rnd_fetch_we", xq[0].we, 0);
      end
      if (ismem && xq.size() > 1) begin
        check("rnd_mem_addr", xq[1].addr, e_addr);
        check("rnd_mem_we", xq[1].we, 32'(op == OP_ST));
        if (op == OP_ST) check("rnd_mem_wdata", xq[1].wdata, e_wd);
      end
    end
    rand_waits = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
